// File: rtl/alu_operand_issue_if.sv
// alu_operand_issue_if: decode-to-ALU operand issue bus
// Carries the decode handshake and payload, execute and memory bypasses, and
// the ALU-side handshake with its registered operand fields.
// slave: the issue buffer; master: the driving side (decode, bypass, ALU).
interface alu_operand_issue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              inValid, inReady;
    logic [REG_W-1:0]  inRs1Addr, inRs2Addr, inRd;
    logic [DATA_W-1:0] inRs1Data, inRs2Data, inImm;
    logic              inUseImm, inRdWrite;
    logic [2:0]        inAluOp;
    logic              exFwdValid, memFwdValid;
    logic [REG_W-1:0]  exFwdRd, memFwdRd;
    logic [DATA_W-1:0] exFwdData, memFwdData;
    logic              outValid, outReady;
    logic [DATA_W-1:0] operand1, operand2;
    logic [2:0]        aluOp;
    logic [REG_W-1:0]  outRd;
    logic              outRdWrite;

    modport slave (
        input  inValid, inRs1Addr, inRs2Addr, inRd, inRs1Data, inRs2Data, inImm,
               inUseImm, inRdWrite, inAluOp, exFwdValid, exFwdRd, exFwdData,
               memFwdValid, memFwdRd, memFwdData, outReady,
        output inReady, outValid, operand1, operand2, aluOp, outRd, outRdWrite
    );

    modport master (
        output inValid, inRs1Addr, inRs2Addr, inRd, inRs1Data, inRs2Data, inImm,
               inUseImm, inRdWrite, inAluOp, exFwdValid, exFwdRd, exFwdData,
               memFwdValid, memFwdRd, memFwdData, outReady,
        input  inReady, outValid, operand1, operand2, aluOp, outRd, outRdWrite
    );
endinterface

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: 2-entry skid buffer issuing bypass-resolved ALU operands
// Ports: clk (rising edge), rst_n (async active-low), flush (drop all entries),
// bus (slave side of alu_operand_issue_if: decode in, bypasses, ALU out).
module alu_operand_issue #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_operand_issue_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // d2 holds the final operand2: the immediate when use_imm, else rs2's value
    typedef struct packed {
        logic [REG_W-1:0]  rs1, rs2, rd;
        logic [DATA_W-1:0] d1, d2;
        logic              use_imm, rd_write;
        logic [2:0]        op;
    } entry_t;

    state_t state, state_n;
    entry_t head, tail, head_n, tail_n, cap;
    logic   in_fire, out_fire;

    logic              ex_v, mem_v;
    logic [REG_W-1:0]  ex_rd, mem_rd;
    logic [DATA_W-1:0] ex_d, mem_d;

    assign ex_v   = bus.exFwdValid;
    assign ex_rd  = bus.exFwdRd;
    assign ex_d   = bus.exFwdData;
    assign mem_v  = bus.memFwdValid;
    assign mem_rd = bus.memFwdRd;
    assign mem_d  = bus.memFwdData;

    // Execute bypass beats memory bypass; x0 never forwards
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
        fwd = (a == '0) ? d : (ex_v && ex_rd == a) ? ex_d : (mem_v && mem_rd == a) ? mem_d : d;
    endfunction

    function automatic entry_t snoop(input entry_t e);
        snoop    = e;
        snoop.d1 = fwd(e.rs1, e.d1);
        snoop.d2 = e.use_imm ? e.d2 : fwd(e.rs2, e.d2);
    endfunction

    assign bus.inReady    = state != TWO;
    assign bus.outValid   = state != EMPTY;
    // Gate with outValid so stale payload never shows while the buffer is empty
    assign bus.operand1   = bus.outValid ? head.d1 : '0;
    assign bus.operand2   = bus.outValid ? head.d2 : '0;
    assign bus.aluOp      = bus.outValid ? head.op : '0;
    assign bus.outRd      = bus.outValid ? head.rd : '0;
    assign bus.outRdWrite = bus.outValid && head.rd_write;

    always_comb begin
        in_fire      = bus.inValid && bus.inReady;
        out_fire     = bus.outValid && bus.outReady;
        cap.rs1      = bus.inRs1Addr;
        cap.rs2      = bus.inRs2Addr;
        cap.rd       = bus.inRd;
        cap.d1       = fwd(bus.inRs1Addr, bus.inRs1Data);
        cap.d2       = bus.inUseImm ? bus.inImm : fwd(bus.inRs2Addr, bus.inRs2Data);
        cap.use_imm  = bus.inUseImm;
        cap.rd_write = bus.inRdWrite;
        cap.op       = bus.inAluOp;
        head_n       = snoop(head);
        tail_n       = snoop(tail);
        state_n      = state;
        case (state)
            ONE: begin
                if (in_fire && out_fire) head_n = cap;
                else if (in_fire) begin
                    tail_n  = cap;
                    state_n = TWO;
                end else if (out_fire) state_n = EMPTY;
            end
            TWO: begin
                if (out_fire) begin
                    head_n  = tail_n;
                    state_n = ONE;
                end
            end
            default: begin
                if (in_fire) begin
                    head_n  = cap;
                    state_n = ONE;
                end
            end
        endcase
        if (flush) state_n = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_n;
            head  <= head_n;
            tail  <= tail_n;
        end
    end
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: directed table-driven and sequence checks of alu_operand_issue
module tb_alu_operand_issue;
    logic clk, rst_n, flush;
    int   checks = 0, errors = 0;

    alu_operand_issue_if #(.DATA_W(32), .REG_W(5)) bus ();

    alu_operand_issue #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        use_imm, rdw;
        logic [2:0]  op;
        logic        ev;
        logic [4:0]  er;
        logic [31:0] ed;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t v[7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fwd_off();
        bus.exFwdValid  = 0;
        bus.exFwdRd     = 0;
        bus.exFwdData   = 0;
        bus.memFwdValid = 0;
        bus.memFwdRd    = 0;
        bus.memFwdData  = 0;
    endtask

    task automatic offer(input vec_t x);
        bus.inValid     = 1;
        bus.inRs1Addr   = x.rs1;
        bus.inRs2Addr   = x.rs2;
        bus.inRd        = x.rd;
        bus.inRs1Data   = x.d1;
        bus.inRs2Data   = x.d2;
        bus.inImm       = x.imm;
        bus.inUseImm    = x.use_imm;
        bus.inRdWrite   = x.rdw;
        bus.inAluOp     = x.op;
        bus.exFwdValid  = x.ev;
        bus.exFwdRd     = x.er;
        bus.exFwdData   = x.ed;
        bus.memFwdValid = x.mv;
        bus.memFwdRd    = x.mr;
        bus.memFwdData  = x.md;
    endtask

    // Plain register-operand entry without bypass activity
    task automatic put(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2);
        vec_t x;
        x = '{rs1, rs2, 5'd1, d1, d2, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
        offer(x);
    endtask

    initial begin
        v[0] = '{5'd3, 5'd0, 5'd1,  32'd5,        32'd0,        32'd7,    1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  32'd5,        32'd7};
        v[1] = '{5'd4, 5'd2, 5'd2,  32'h11,       32'h22,       32'h0,    1'b0, 1'b1, 3'd1, 1'b1, 5'd4, 32'hAA,       1'b1, 5'd4, 32'hBB, 32'hAA,       32'h22};
        v[2] = '{5'd0, 5'd0, 5'd3,  32'h33,       32'h44,       32'h0,    1'b0, 1'b1, 3'd2, 1'b1, 5'd0, 32'hAA,       1'b1, 5'd0, 32'hBB, 32'h33,       32'h44};
        v[3] = '{5'd5, 5'd5, 5'd4,  32'h1,        32'h2,        32'h0,    1'b0, 1'b1, 3'd3, 1'b1, 5'd6, 32'hCC,       1'b1, 5'd5, 32'hBB, 32'hBB,       32'hBB};
        v[4] = '{5'd1, 5'd6, 5'd5,  32'h9,        32'h8,        32'h1234, 1'b1, 1'b1, 3'd4, 1'b1, 5'd6, 32'hCC,       1'b0, 5'd0, 32'h0,  32'h9,        32'h1234};
        v[5] = '{5'd7, 5'd8, 5'd31, 32'hFFFFFFFF, 32'h80000000, 32'h0,    1'b0, 1'b0, 3'd7, 1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 32'h0,  32'hFFFFFFFF, 32'h12345678};
        v[6] = '{5'd9, 5'd9, 5'd6,  32'h0,        32'h0,        32'h0,    1'b0, 1'b1, 3'd5, 1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 32'h88, 32'h99,       32'h99};

        rst_n = 0;
        flush = 0;
        bus.outReady = 0;
        put(5'd0, 32'h0, 5'd0, 32'h0);
        bus.inValid = 0;
        fwd_off();
        tick();
        tick();
        chk("reset outValid", 32'(bus.outValid), 32'd0);
        chk("reset inReady", 32'(bus.inReady), 32'd1);
        chk("reset operand1", bus.operand1, 32'd0);
        chk("reset operand2", bus.operand2, 32'd0);
        chk("reset aluOp", 32'(bus.aluOp), 32'd0);
        chk("reset outRd", 32'(bus.outRd), 32'd0);
        chk("reset outRdWrite", 32'(bus.outRdWrite), 32'd0);
        rst_n = 1;
        tick();

        // Back-to-back vectors with outReady high: each is captured while the previous one leaves
        bus.outReady = 1;
        for (int i = 0; i < 7; i++) begin
            offer(v[i]);
            tick();
            chk($sformatf("vec%0d outValid", i), 32'(bus.outValid), 32'd1);
            chk($sformatf("vec%0d operand1", i), bus.operand1, v[i].e1);
            chk($sformatf("vec%0d operand2", i), bus.operand2, v[i].e2);
            chk($sformatf("vec%0d aluOp", i), 32'(bus.aluOp), 32'(v[i].op));
            chk($sformatf("vec%0d outRd", i), 32'(bus.outRd), 32'(v[i].rd));
            chk($sformatf("vec%0d outRdWrite", i), 32'(bus.outRdWrite), 32'(v[i].rdw));
        end
        bus.inValid = 0;
        fwd_off();
        tick();
        chk("drain outValid", 32'(bus.outValid), 32'd0);

        // Backpressure: A, B fill the buffer, C stalls, then A, B, C drain in order
        bus.outReady = 0;
        put(5'd10, 32'hA, 5'd0, 32'h0);
        tick();
        put(5'd10, 32'hB, 5'd0, 32'h0);
        tick();
        chk("full inReady", 32'(bus.inReady), 32'd0);
        chk("full head A", bus.operand1, 32'hA);
        put(5'd10, 32'hC, 5'd0, 32'h0);
        tick();
        chk("stall inReady", 32'(bus.inReady), 32'd0);
        chk("stall head A", bus.operand1, 32'hA);
        bus.outReady = 1;
        tick();
        chk("drain head B", bus.operand1, 32'hB);
        chk("drain inReady", 32'(bus.inReady), 32'd1);
        tick();
        chk("drain head C", bus.operand1, 32'hC);
        chk("drain C valid", 32'(bus.outValid), 32'd1);
        bus.inValid = 0;
        tick();
        chk("drain empty", 32'(bus.outValid), 32'd0);
        chk("drain inReady", 32'(bus.inReady), 32'd1);

        // Held tail snoops a memory bypass pulse on rs2
        bus.outReady = 0;
        put(5'd12, 32'h10, 5'd2, 32'h20);
        tick();
        put(5'd13, 32'h30, 5'd6, 32'h1);
        tick();
        bus.inValid = 0;
        bus.memFwdValid = 1;
        bus.memFwdRd = 5'd6;
        bus.memFwdData = 32'h55;
        tick();
        fwd_off();
        tick();
        bus.outReady = 1;
        chk("snoop head op1", bus.operand1, 32'h10);
        chk("snoop head op2", bus.operand2, 32'h20);
        tick();
        chk("snoop tail op1", bus.operand1, 32'h30);
        chk("snoop tail op2", bus.operand2, 32'h55);
        tick();
        chk("snoop empty", 32'(bus.outValid), 32'd0);

        // Flush in TWO with a simultaneous offer
        bus.outReady = 0;
        put(5'd1, 32'h1, 5'd0, 32'h0);
        tick();
        put(5'd1, 32'h2, 5'd0, 32'h0);
        tick();
        chk("preflush inReady", 32'(bus.inReady), 32'd0);
        put(5'd1, 32'hDEAD, 5'd0, 32'h0);
        flush = 1;
        tick();
        flush = 0;
        bus.inValid = 0;
        chk("flush outValid", 32'(bus.outValid), 32'd0);
        chk("flush inReady", 32'(bus.inReady), 32'd1);
        chk("flush operand1", bus.operand1, 32'd0);
        bus.outReady = 1;
        tick();
        chk("postflush outValid", 32'(bus.outValid), 32'd0);
        tick();
        chk("postflush outValid2", 32'(bus.outValid), 32'd0);

        // Flush while an offer would be accepted into an empty buffer
        put(5'd1, 32'hBEEF, 5'd0, 32'h0);
        flush = 1;
        tick();
        flush = 0;
        bus.inValid = 0;
        chk("flush offer dropped", 32'(bus.outValid), 32'd0);

        // Asynchronous reset while an entry is presented
        bus.outReady = 0;
        put(5'd3, 32'h77, 5'd0, 32'h0);
        bus.inAluOp = 3'd6;
        tick();
        bus.inValid = 0;
        chk("prereset outValid", 32'(bus.outValid), 32'd1);
        chk("prereset operand1", bus.operand1, 32'h77);
        #2 rst_n = 0;
        #1;
        chk("async outValid", 32'(bus.outValid), 32'd0);
        chk("async operand1", bus.operand1, 32'd0);
        chk("async aluOp", 32'(bus.aluOp), 32'd0);
        chk("async inReady", 32'(bus.inReady), 32'd1);
        tick();
        rst_n = 1;
        tick();
        chk("postreset outValid", 32'(bus.outValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
